// File: rtl/conv_window_ctrl_if.sv
// Signal bundle between the window sequencer, its pixel memory, the
// convolution datapath and the downstream result consumer.
interface conv_window_ctrl_if #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int ADDR_W    = 16
);
  logic                                             start;
  logic                                             busy;
  logic                                             done;
  logic                                             mem_ren;
  logic        [ADDR_W-1:0]                         mem_addr;
  logic signed [WIDTH_BIT-1:0]                      mem_rdata;
  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]  win;
  logic signed [WIDTH_BIT-1:0]                      conv_res;
  logic signed [WIDTH_BIT-1:0]                      out_data;
  logic        [ADDR_W-1:0]                         out_row;
  logic        [ADDR_W-1:0]                         out_col;
  logic                                             out_valid;
  logic                                             out_ready;

  modport master (
    input  start, mem_rdata, conv_res, out_ready,
    output busy, done, mem_ren, mem_addr, win, out_data, out_row, out_col, out_valid
  );

  modport slave (
    output start, mem_rdata, conv_res, out_ready,
    input  busy, done, mem_ren, mem_addr, win, out_data, out_row, out_col, out_valid
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Window sequencer: fetches each SIZE x SIZE window from a synchronous-read
// image memory, captures the datapath result and streams it out in raster order.
module conv_window_ctrl #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                   clock,
  input  logic                   nreset,
  conv_window_ctrl_if.master     bus
);

  localparam int OH    = IMG_H - SIZE + 1;
  localparam int OW    = IMG_W - SIZE + 1;
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(SIZE - 1);
  localparam logic [ADDR_W-1:0] OW_MAX  = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OH_MAX  = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  typedef enum logic [2:0] {IDLE, FETCH, LAST, CAPT, OUT} state_t;

  state_t                                           state_q, state_d;
  logic        [IDX_W-1:0]                          i_q, i_d, j_q, j_d;
  logic        [IDX_W-1:0]                          wi_q, wj_q;
  logic                                             rvld_q;
  logic        [ADDR_W-1:0]                         orow_q, orow_d, ocol_q, ocol_d;
  logic signed [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0]  win_q;
  logic signed [WIDTH_BIT-1:0]                      out_data_q;
  logic        [ADDR_W-1:0]                         out_row_q, out_col_q;
  logic                                             out_valid_q, done_q;
  logic                                             fetch_last, pos_last, hs;

  assign fetch_last = (i_q == IDX_MAX) && (j_q == IDX_MAX);
  assign pos_last   = (orow_q == OH_MAX) && (ocol_q == OW_MAX);
  assign hs         = out_valid_q && bus.out_ready;

  always_ff @(posedge clock) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   if (fetch_last) state_d = LAST;
      LAST:    state_d = CAPT;
      CAPT:    state_d = OUT;
      OUT:     if (hs) state_d = pos_last ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q != IDLE);
    bus.mem_ren  = 1'b0;
    bus.mem_addr = '0;
    if (state_q == FETCH) begin
      bus.mem_ren  = 1'b1;
      bus.mem_addr = (orow_q + ADDR_W'(i_q)) * IMG_W_A + ocol_q + ADDR_W'(j_q);
    end
  end

  // Fetch indices advance column-first inside the window; output position
  // advances only on a handshake that is not the frame's last one.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          i_d    = '0;
          j_d    = '0;
          orow_d = '0;
          ocol_d = '0;
        end
      end
      FETCH: begin
        if (j_q == IDX_MAX) begin
          j_d = '0;
          i_d = (i_q == IDX_MAX) ? '0 : i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      OUT: begin
        if (hs && !pos_last) begin
          if (ocol_q == OW_MAX) begin
            ocol_d = '0;
            orow_d = orow_q + 1'b1;
          end else begin
            ocol_d = ocol_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      i_q         <= '0;
      j_q         <= '0;
      wi_q        <= '0;
      wj_q        <= '0;
      rvld_q      <= 1'b0;
      orow_q      <= '0;
      ocol_q      <= '0;
      win_q       <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      // Read data lands one cycle after issue, so the write index lags by one.
      wi_q   <= i_q;
      wj_q   <= j_q;
      rvld_q <= (state_q == FETCH);
      if (rvld_q) win_q[wi_q][wj_q] <= bus.mem_rdata;
      if (state_q == CAPT) begin
        out_data_q  <= bus.conv_res;
        out_row_q   <= orow_q;
        out_col_q   <= ocol_q;
        out_valid_q <= 1'b1;
      end else if (hs) begin
        out_valid_q <= 1'b0;
      end
      done_q <= (state_q == OUT) && hs && pos_last;
    end
  end

  assign bus.done      = done_q;
  assign bus.win       = win_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign bus.out_valid = out_valid_q;

endmodule
